// File: rtl/i2c_apb_pkg.sv
// Shared constants for the I2C APB slave: default FIFO geometry
// and register map offsets.
package i2c_apb_pkg;

    localparam int I2C_DWIDTH     = 32;
    localparam int I2C_FIFO_DEPTH = 16;

    localparam int ADDR_TX      = 0;
    localparam int ADDR_RX      = 4;
    localparam int ADDR_CFG     = 8;
    localparam int ADDR_TIMEOUT = 12;

    localparam int CFG_W = 14;

endpackage

// File: rtl/i2c_fifo_mem.sv
// FIFO storage: DEPTH x DWIDTH register array with a synchronous
// write port and an asynchronous read port.
module i2c_fifo_mem
    import i2c_apb_pkg::*;
#(
    parameter int DWIDTH = I2C_DWIDTH,
    parameter int DEPTH  = I2C_FIFO_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/i2c_apb_fifo.sv
// First-word-fall-through FIFO between the APB front-end and the
// I2C core, with occupancy flags and sticky overflow/underflow.
module i2c_apb_fifo
    import i2c_apb_pkg::*;
#(
    parameter int DWIDTH    = I2C_DWIDTH,
    parameter int DEPTH     = I2C_FIFO_DEPTH,
    parameter int AF_MARGIN = 2
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic                       WR_ENA,
    input  logic [DWIDTH-1:0]          WR_DATA,
    input  logic                       RD_ENA,
    output logic [DWIDTH-1:0]          RD_DATA,
    output logic                       EMPTY,
    output logic                       FULL,
    output logic                       ALMOST_FULL,
    output logic [$clog2(DEPTH):0]     COUNT,
    input  logic                       ERR_CLR,
    output logic                       OVERFLOW,
    output logic                       UNDERFLOW,
    output logic                       ERROR
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;
    logic              push;
    logic              pop;
    logic              ovf_evt;
    logic              unf_evt;
    logic [DWIDTH-1:0] head;

    assign EMPTY       = (count == '0);
    assign FULL        = (count == CW'(DEPTH));
    assign ALMOST_FULL = (count >= CW'(DEPTH - AF_MARGIN));

    assign pop     = RD_ENA & ~EMPTY;
    assign push    = WR_ENA & (~FULL | pop);
    assign ovf_evt = WR_ENA & FULL & ~pop;
    assign unf_evt = RD_ENA & EMPTY;

    i2c_fifo_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk    (PCLK),
        .we     (push),
        .waddr  (wr_ptr),
        .wdata  (WR_DATA),
        .raddr  (rd_ptr),
        .rdata  (head)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            // A fresh error event outranks a clear in the same cycle
            overflow  <= ovf_evt | (overflow & ~ERR_CLR);
            underflow <= unf_evt | (underflow & ~ERR_CLR);
        end
    end

    assign RD_DATA   = EMPTY ? '0 : head;
    assign COUNT     = count;
    assign OVERFLOW  = overflow;
    assign UNDERFLOW = underflow;
    assign ERROR     = overflow | underflow;

endmodule

// File: tb/tb_i2c_apb_fifo.sv
// Randomized and directed checks of i2c_apb_fifo against a
// queue-based reference model.
module tb_i2c_apb_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AFM   = 2;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          WR_ENA;
    logic [DW-1:0] WR_DATA;
    logic          RD_ENA;
    logic [DW-1:0] RD_DATA;
    logic          EMPTY;
    logic          FULL;
    logic          ALMOST_FULL;
    logic [4:0]    COUNT;
    logic          ERR_CLR;
    logic          OVERFLOW;
    logic          UNDERFLOW;
    logic          ERROR;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    bit            m_ovf;
    bit            m_unf;

    i2c_apb_fifo #(
        .DWIDTH    (DW),
        .DEPTH     (DEPTH),
        .AF_MARGIN (AFM)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .WR_ENA      (WR_ENA),
        .WR_DATA     (WR_DATA),
        .RD_ENA      (RD_ENA),
        .RD_DATA     (RD_DATA),
        .EMPTY       (EMPTY),
        .FULL        (FULL),
        .ALMOST_FULL (ALMOST_FULL),
        .COUNT       (COUNT),
        .ERR_CLR     (ERR_CLR),
        .OVERFLOW    (OVERFLOW),
        .UNDERFLOW   (UNDERFLOW),
        .ERROR       (ERROR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DW-1:0] head;
        int n;
        n = q.size();
        head = (n == 0) ? '0 : q[0];
        chk({tag, ":count"}, DW'(COUNT), DW'(n));
        chk({tag, ":empty"}, DW'(EMPTY), DW'(n == 0));
        chk({tag, ":full"}, DW'(FULL), DW'(n == DEPTH));
        chk({tag, ":afull"}, DW'(ALMOST_FULL), DW'(n >= DEPTH - AFM));
        chk({tag, ":rdata"}, RD_DATA, head);
        chk({tag, ":ovf"}, DW'(OVERFLOW), DW'(m_ovf));
        chk({tag, ":unf"}, DW'(UNDERFLOW), DW'(m_unf));
        chk({tag, ":err"}, DW'(ERROR), DW'(m_ovf | m_unf));
    endtask

    // One clock: apply inputs, advance model, compare after the edge
    task automatic step(input string tag, input bit rst, input bit wr,
                        input logic [DW-1:0] wd, input bit rd,
                        input bit clr);
        bit was_full;
        bit was_empty;
        bit do_pop;
        PRESET  = rst;
        WR_ENA  = wr;
        WR_DATA = wd;
        RD_ENA  = rd;
        ERR_CLR = clr;
        #1;
        if (rd && q.size() > 0) begin
            chk({tag, ":popword"}, RD_DATA, q[0]);
        end
        @(posedge PCLK);
        if (rst) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            do_pop    = rd && !was_empty;
            m_ovf = (wr && was_full && !do_pop) || (m_ovf && !clr);
            m_unf = (rd && was_empty) || (m_unf && !clr);
            if (do_pop) void'(q.pop_front());
            if (wr && (!was_full || do_pop)) q.push_back(wd);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [DW-1:0] d;
        bit w;
        bit r;
        PRESET = 1'b1;
        WR_ENA = 1'b0;
        WR_DATA = '0;
        RD_ENA = 1'b0;
        ERR_CLR = 1'b0;
        m_ovf = 0;
        m_unf = 0;

        step("reset", 1, 0, '0, 0, 0);
        step("reset2", 1, 1, 32'hFFFF_FFFF, 1, 0);
        step("idle", 0, 0, '0, 0, 0);

        for (int i = 1; i <= DEPTH; i++) begin
            step("fill", 0, 1, 32'hA5A5_0000 + DW'(i), 0, 0);
        end

        step("ovf_push", 0, 1, 32'hDEAD_BEEF, 0, 0);
        step("ovf_hold", 0, 0, '0, 0, 0);
        step("ovf_clr", 0, 0, '0, 0, 1);

        step("full_wr_rd", 0, 1, 32'h1234_5678, 1, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 0, 0, '0, 1, 0);
        end

        step("empty_wr_rd", 0, 1, 32'h0000_0055, 1, 0);
        step("pop55", 0, 0, '0, 1, 0);
        step("unf_again_clr", 0, 0, '0, 1, 1);
        step("unf_clr", 0, 0, '0, 0, 1);

        for (int i = 0; i < 3; i++) begin
            step("pre3", 0, 1, $urandom, 0, 0);
        end
        for (int i = 0; i < 40; i++) begin
            step("wrap", 0, 1, $urandom, 1, 0);
        end
        step("mid_reset", 1, 1, $urandom, 1, 0);
        step("post_reset", 0, 0, '0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            d = $urandom;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            step("rand", ($urandom_range(0, 99) < 2), w, d, r,
                 ($urandom_range(0, 99) < 8));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
